// File: rtl/spwm_ctrl_pkg.sv
// Shared types and defaults for the SPWM ramp controller.
package spwm_ctrl_pkg;

    localparam int unsigned FREQ_W = 20;

    localparam logic [FREQ_W-1:0] F_MAX_DEFAULT    = 20'd400000;
    localparam logic [FREQ_W-1:0] TRI_FREQ_DEFAULT = 20'd200000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP      = 3'd1,
        ST_RUN       = 3'd2,
        ST_STOP_RAMP = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp-step prescaler: one-cycle tick every TICK_DIV enabled cycles; clr restarts the count.
module ramp_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/spwm_ramp_controller.sv
// Soft-start/soft-stop sequencer for the SPWM phase generator.
// Optional command watchdog enabled by defining SPWM_CMD_WATCHDOG_EN.
module spwm_ramp_controller
    import spwm_ctrl_pkg::*;
#(
    parameter int unsigned       FREQ_W   = spwm_ctrl_pkg::FREQ_W,
    parameter int unsigned       TICK_DIV = 50000,
    parameter int unsigned       STEP     = 16,
    parameter logic [FREQ_W-1:0] F_MAX    = F_MAX_DEFAULT,
    parameter logic [FREQ_W-1:0] TRI_FREQ = TRI_FREQ_DEFAULT
`ifdef SPWM_CMD_WATCHDOG_EN
    ,
    parameter int unsigned       WDOG_CYCLES = 10000000
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [FREQ_W-1:0] cmd_freq,
    input  logic              start,
    input  logic              stop,
    input  logic              fault_in,
    input  logic              fault_clr,
    output logic [FREQ_W-1:0] sine_freq,
    output logic [FREQ_W-1:0] triangular_freq,
    output logic              gen_reset,
    output logic              gate_en,
    output logic [2:0]        state,
    output logic              wdog_timeout
);

    localparam logic [FREQ_W:0] STEP_X = (FREQ_W + 1)'(STEP);

    state_t            fsm, fsm_next;
    logic [FREQ_W-1:0] target, target_next, sine_next;
    logic [FREQ_W-1:0] clamped, eff_target, stepped;
    logic [FREQ_W:0]   up_sum, dn_lim;
    logic              gen_reset_next, gate_en_next;
    logic              accept, tick, tick_clr, tick_en, wd_expire;

    assign state      = fsm;
    assign accept     = cmd_valid && cmd_ready;
    assign clamped    = (cmd_freq > F_MAX) ? F_MAX : cmd_freq;
    assign eff_target = accept ? clamped : target;
    assign up_sum     = {1'b0, sine_freq} + STEP_X;
    assign dn_lim     = {1'b0, target} + STEP_X;

    // One step toward target, computed one bit wider so neither direction can wrap.
    always_comb begin
        stepped = sine_freq;
        if (sine_freq < target) begin
            stepped = (up_sum >= {1'b0, target}) ? target : up_sum[FREQ_W-1:0];
        end else if (sine_freq > target) begin
            stepped = ({1'b0, sine_freq} <= dn_lim) ? target : sine_freq - STEP_X[FREQ_W-1:0];
        end
    end

    assign tick_en  = (fsm == ST_RAMP) || (fsm == ST_STOP_RAMP);
    assign tick_clr = ((fsm_next == ST_RAMP) && (fsm != ST_RAMP)) ||
                      ((fsm_next == ST_STOP_RAMP) && (fsm != ST_STOP_RAMP));

    ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .en    (tick_en),
        .tick  (tick)
    );

`ifdef SPWM_CMD_WATCHDOG_EN
    logic [31:0] wcnt;

    assign wd_expire = ((fsm == ST_RAMP) || (fsm == ST_RUN)) && (wcnt == WDOG_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt         <= '0;
            wdog_timeout <= 1'b0;
        end else begin
            if (!(fsm_next inside {ST_RAMP, ST_RUN}) || accept ||
                ((fsm_next == ST_RAMP) && (fsm != ST_RAMP))) begin
                wcnt <= '0;
            end else begin
                wcnt <= wcnt + 32'd1;
            end
            if (fault_clr) begin
                wdog_timeout <= 1'b0;
            end else if (wd_expire && !fault_in) begin
                wdog_timeout <= 1'b1;
            end
        end
    end
`else
    assign wd_expire    = 1'b0;
    assign wdog_timeout = 1'b0;
`endif

    always_comb begin
        fsm_next       = fsm;
        target_next    = target;
        sine_next      = sine_freq;
        gen_reset_next = gen_reset;
        gate_en_next   = gate_en;
        if (fault_in && (fsm != ST_FAULT)) begin
            fsm_next       = ST_FAULT;
            target_next    = '0;
            sine_next      = '0;
            gen_reset_next = 1'b1;
            gate_en_next   = 1'b0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (accept) target_next = clamped;
                    if (start && (eff_target != '0)) begin
                        fsm_next       = ST_RAMP;
                        gen_reset_next = 1'b0;
                        gate_en_next   = 1'b1;
                    end
                end
                ST_RAMP, ST_RUN: begin
                    // stop drops any command accepted in the same cycle
                    if (stop || wd_expire) begin
                        fsm_next    = ST_STOP_RAMP;
                        target_next = '0;
                    end else begin
                        if (accept) target_next = clamped;
                        if (fsm == ST_RUN) begin
                            if (accept && (clamped != sine_freq)) fsm_next = ST_RAMP;
                        end else begin
                            if (tick) sine_next = stepped;
                            if (sine_freq == eff_target) fsm_next = ST_RUN;
                        end
                    end
                end
                ST_STOP_RAMP: begin
                    target_next = '0;
                    if (tick) sine_next = stepped;
                    if (sine_freq == '0) begin
                        fsm_next       = ST_IDLE;
                        gen_reset_next = 1'b1;
                        gate_en_next   = 1'b0;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr && !fault_in) fsm_next = ST_IDLE;
                end
                default: fsm_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm             <= ST_IDLE;
            target          <= '0;
            sine_freq       <= '0;
            triangular_freq <= TRI_FREQ;
            gen_reset       <= 1'b1;
            gate_en         <= 1'b0;
            cmd_ready       <= 1'b1;
        end else begin
            fsm             <= fsm_next;
            target          <= target_next;
            sine_freq       <= sine_next;
            triangular_freq <= TRI_FREQ;
            gen_reset       <= gen_reset_next;
            gate_en         <= gate_en_next;
            cmd_ready       <= fsm_next inside {ST_IDLE, ST_RAMP, ST_RUN};
        end
    end

endmodule

// File: doc/spwm_ramp_controller.md
Name: spwm_ramp_controller

Overview:
Sequencer for the three-phase SPWM phase generator. It takes frequency commands over a valid/ready handshake and ramps the generator's sine_freq toward the target in fixed steps (soft start and soft stop). It also drives the generator's reset and the downstream gate enable, and latches faults. It sits between the host/command interface and the phase generator; triangular_freq is held at a configured carrier value.

Parameters:
FREQ_W, 20, width of frequency words (matches generator frequency inputs)
TICK_DIV, 50000, clk cycles per ramp step (>=2)
STEP, 16, sine_freq increment/decrement per ramp tick
F_MAX, 20'd400000, command clamp ceiling
TRI_FREQ, 20'd200000, fixed carrier frequency driven on triangular_freq
WDOG_CYCLES, 10000000, command watchdog timeout (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cmd_valid  in  1  frequency command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_freq  in  FREQ_W  requested sine frequency
start  in  1  single-cycle start request
stop  in  1  single-cycle controlled-stop request
fault_in  in  1  external fault (level)
fault_clr  in  1  single-cycle fault clear
sine_freq  out  FREQ_W  to generator sine_freq
triangular_freq  out  FREQ_W  to generator triangular_freq
gen_reset  out  1  to generator reset
gate_en  out  1  power-stage gate enable
state  out  3  encoded FSM state
wdog_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset values: sine_freq=0, triangular_freq=TRI_FREQ, gen_reset=1, gate_en=0, cmd_ready=1, state=IDLE, wdog_timeout=0, internal target=0, tick counter=0. All outputs are registered.
- States: IDLE=0, RAMP=1, RUN=2, STOP_RAMP=3, FAULT=4.
- cmd_ready=1 in IDLE, RAMP and RUN; 0 in STOP_RAMP and FAULT.
- Command acceptance: target <= min(cmd_freq, F_MAX), visible from the next cycle.
- IDLE:
  - start with effective target!=0 -> RAMP; gen_reset=0 and gate_en=1 from the next cycle.
  - start with target==0 is ignored.
  - The effective target includes a command accepted in the same cycle.
- Tick counter: counts 0..TICK_DIV-1 and clears on entry to RAMP or STOP_RAMP. A tick pulse occurs when count==TICK_DIV-1.
- RAMP, on tick:
  - sine_freq<target -> sine_freq=min(sine_freq+STEP, target).
  - sine_freq>target -> sine_freq=max(sine_freq-STEP, target).
  - Arithmetic is FREQ_W+1 bits; there is no wrap.
- RAMP, any cycle with sine_freq==target -> RUN next cycle.
- RUN: an accepted command with clamped value != sine_freq -> RAMP. An equal value stays in RUN.
- STOP_RAMP: target forced to 0; ramps down on ticks. On reaching sine_freq==0 -> IDLE, with gen_reset=1 and gate_en=0 next cycle.
- stop in RAMP or RUN -> STOP_RAMP. stop in IDLE, STOP_RAMP or FAULT is ignored.
- FAULT:
  - fault_in=1 in any non-FAULT state -> FAULT next cycle: gate_en=0, gen_reset=1, sine_freq=0, target=0.
  - Exit to IDLE only on fault_clr && !fault_in; fault_clr is ignored while fault_in=1.
- Priority on simultaneous events: fault_in > stop > start > command.
- A command accepted in the same cycle as stop is discarded.
- triangular_freq is constant TRI_FREQ except under reset.

Optional Feature:
SPWM_CMD_WATCHDOG_EN
- With the macro: a counter clears on every accepted command and on entry to RAMP.
  - In RAMP or RUN, reaching WDOG_CYCLES forces STOP_RAMP and sets wdog_timeout=1.
  - wdog_timeout clears on reset or fault_clr.
- Without the macro: no counter; wdog_timeout is tied to 0.

Decomposition:
- Package spwm_ctrl_pkg: state enum (3-bit), FREQ_W, default F_MAX and TRI_FREQ constants.
- Sub-module ramp_tick_gen: the TICK_DIV prescaler, with inputs clr and en and output tick pulse.

Test Plan:
Bench parameters TICK_DIV=4, STEP=10.
1. Reset -> sine_freq=0, gen_reset=1, gate_en=0, state=0, cmd_ready=1, triangular_freq=TRI_FREQ.
2. Accept cmd 35, then start -> gate_en=1, sine_freq steps 10, 20, 30, 35 every 4 clk; state RUN one cycle after reaching 35.
3. In RUN, cmd 15 -> RAMP, 25 then 15, then RUN. Then cmd 15 again -> stays RUN.
4. cmd F_MAX+100 -> target clamps to F_MAX. stop with simultaneous cmd -> cmd discarded, ramp to 0, then IDLE with gen_reset=1 and gate_en=0.
5. fault_in pulse mid-RAMP with simultaneous stop and start -> FAULT next cycle, sine_freq=0, gate_en=0. fault_clr while fault_in=1 -> stays FAULT. fault_in=0 then fault_clr -> IDLE.
6. (SPWM_CMD_WATCHDOG_EN, WDOG_CYCLES=50) RUN with no commands for 50 clk -> STOP_RAMP, wdog_timeout=1, ramp to 0.
